// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-length helper and loader state encoding
package aes_pkg;

  localparam logic [1:0] AES_MODE_128  = 2'd0;
  localparam logic [1:0] AES_MODE_192  = 2'd1;
  localparam logic [1:0] AES_MODE_256  = 2'd2;
  localparam logic [1:0] AES_MODE_RSVD = 2'd3;

  localparam int AES_DATA_BYTES    = 16;
  localparam int AES_MAX_KEY_BYTES = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_DATA  = 3'd1,
    ST_RX_KEY   = 3'd2,
    ST_START    = 3'd3,
    ST_WAIT_ENG = 3'd4
  } loader_state_t;

  // Key length in bytes for a key-size mode; the reserved code never starts a load.
  function automatic logic [5:0] key_bytes(input logic [1:0] mode);
    case (mode)
      AES_MODE_128: key_bytes = 6'd16;
      AES_MODE_192: key_bytes = 6'd24;
      default:      key_bytes = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - byte-stream loader for one AES plaintext block and key
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int DATA_BYTES    = AES_DATA_BYTES,
  parameter int MAX_KEY_BYTES = AES_MAX_KEY_BYTES
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic                         in_valid,
  input  logic [7:0]                   in_byte,
  output logic                         in_ready,
  input  logic                         abort,
  input  logic                         engine_done,
  output logic [0:8*DATA_BYTES-1]      data_out,
  output logic [0:8*MAX_KEY_BYTES-1]   key_out,
  output logic [1:0]                   key_mode,
  output logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int KW  = 8 * MAX_KEY_BYTES;
  localparam int DIW = $clog2(DW);
  localparam int KIW = $clog2(KW);
  localparam logic [4:0] DATA_LAST = 5'(DATA_BYTES - 1);

  loader_state_t    r_state;
  loader_state_t    w_next;
  logic [4:0]       r_byte_cnt;
  logic [1:0]       r_key_mode;
  logic [0:DW-1]    r_data;
  logic [0:KW-1]    r_key;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_in_ready;
  logic             w_start;
  logic             w_accept;
  logic [4:0]       w_key_last;
  logic [DIW-1:0]   w_data_idx;
  logic [KIW-1:0]   w_key_idx;

  assign w_accept   = in_valid && w_in_ready;
  assign w_key_last = 5'(key_bytes(r_key_mode) - 6'd1);
  assign w_data_idx = DIW'({r_byte_cnt, 3'b000});
  assign w_key_idx  = KIW'({r_byte_cnt, 3'b000});

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode plus the combinational handshake and start pulse.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = (mode != AES_MODE_RSVD);
        if (in_valid && w_in_ready) w_next = ST_RX_DATA;
      end
      ST_RX_DATA: begin
        w_in_ready = 1'b1;
        if (in_valid && r_byte_cnt == DATA_LAST) w_next = ST_RX_KEY;
      end
      ST_RX_KEY: begin
        w_in_ready = 1'b1;
        if (in_valid && r_byte_cnt == w_key_last) w_next = ST_START;
      end
      ST_START: begin
        w_start = 1'b1;
        w_next  = ST_WAIT_ENG;
      end
      ST_WAIT_ENG: begin
        if (engine_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (abort) begin
      w_next  = ST_IDLE;
      w_start = 1'b0;
    end
  end

  // Byte steering, counters and status flags; abort keeps the stale block contents.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_key_mode <= '0;
      r_data     <= '0;
      r_key      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (abort) begin
      r_byte_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid && mode == AES_MODE_RSVD) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            r_key_mode  <= mode;
            r_data[0:7] <= in_byte;
            r_byte_cnt  <= 5'd1;
            r_busy      <= 1'b1;
          end
        end
        ST_RX_DATA: begin
          if (w_accept) begin
            r_data[w_data_idx +: 8] <= in_byte;
            if (r_byte_cnt == DATA_LAST) begin
              r_byte_cnt <= '0;
              r_key      <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 5'd1;
            end
          end
        end
        ST_RX_KEY: begin
          if (w_accept) begin
            r_key[w_key_idx +: 8] <= in_byte;
            if (r_byte_cnt == w_key_last) r_byte_cnt <= '0;
            else                          r_byte_cnt <= r_byte_cnt + 5'd1;
          end
        end
        ST_WAIT_ENG: begin
          if (engine_done) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = w_in_ready;
  assign start    = w_start;
  assign data_out = r_data;
  assign key_out  = r_key;
  assign key_mode = r_key_mode;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule
